// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = in_1 - in_2 - b_in, with borrow-out.
module full_subtractor (
  input  logic in_1,
  input  logic in_2,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = in_1 ^ in_2 ^ b_in;
  assign b_out = (~in_1 & in_2) | (~(in_1 ^ in_2) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell, LSB-first over WIDTH cycles,
// sequenced by a start/busy/done handshake.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             d_bit, bo_bit;
  logic             accept, last;

  full_subtractor u_fs (
    .in_1  (a_sr[0]),
    .in_2  (b_sr[0]),
    .b_in  (borrow),
    .diff  (d_bit),
    .b_out (bo_bit)
  );

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are only loaded on accept, so start/inputs during RUN/DONE are inert.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= in_1;
      b_sr   <= in_2;
      res_sr <= '0;
      borrow <= b_in;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      borrow <= bo_bit;
      cnt    <= cnt + 1'b1;
    end
  end

  // Result registers update only on the final bit, so they hold the previous result during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff  <= '0;
      b_out <= 1'b0;
    end else if (state == RUN && last) begin
      diff  <= {d_bit, res_sr[WIDTH-1:1]};
      b_out <= bo_bit;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  logic         clk, rst, start, b_in;
  logic [W-1:0] in_1, in_2;
  logic         busy, done, b_out;
  logic [W-1:0] diff;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   done_cnt     = 0;
  int   cyc          = 0;
  logic prev_done    = 1'b0;
  exp_t mon_e;
  exp_t exp_q[$];
  int   done_cyc[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in_1  (in_1),
    .in_2  (in_2),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0] r;
    exp_t       e;
    r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.d  = r[W-1:0];
    e.bo = r[W];
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      tests_run++;
      if (prev_done) begin
        tests_failed++;
        $display("FAIL done_width done high two cycles in a row, required one-cycle pulse");
      end else if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_done diff=%0d b_out=%0d, required no done pulse", diff, b_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (diff !== mon_e.d || b_out !== mon_e.bo) begin
          tests_failed++;
          $display("FAIL result got diff=%0d b_out=%0b, expected diff=%0d b_out=%0b",
                   diff, b_out, mon_e.d, mon_e.bo);
        end
      end
    end
    prev_done = rst ? 1'b0 : done;
  end

  // Accept one operation and wait for done; lat = edges after the accepting edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, output int lat);
    @(negedge clk);
    in_1 = a; in_2 = b; b_in = bi; start = 1'b1;
    exp_q.push_back(model(a, b, bi));
    @(posedge clk); #1;
    start = 1'b0;
    in_1 = W'($urandom); in_2 = W'($urandom); b_in = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 50);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_1 = '0; in_2 = '0; b_in = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || b_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state busy=%b done=%b diff=%0d b_out=%b, expected all 0", busy, done, diff, b_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    run_op(8'd200, 8'd55, 1'b0, lat);
    tests_run++;
    if (lat !== 8) begin
      tests_failed++;
      $display("FAIL basic_latency got %0d cycles, expected 8", lat);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd145 || b_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_after_done busy=%b done=%b diff=%0d b_out=%b, expected 0 0 145 0",
               busy, done, diff, b_out);
    end
  endtask

  task automatic test_underflow();
    int lat;
    run_op(8'd5, 8'd10, 1'b0, lat);
    tests_run++;
    if (lat !== 8) begin
      tests_failed++;
      $display("FAIL underflow_latency got %0d, expected 8", lat);
    end
    @(posedge clk); #1;
    tests_run++;
    if (diff !== 8'd251 || b_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_hold diff=%0d b_out=%b, expected 251 1", diff, b_out);
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] av [3] = '{8'd0,   8'd255, 8'd255};
    logic [W-1:0] bv [3] = '{8'd0,   8'd255, 8'd0};
    logic         iv [3] = '{1'b1,   1'b1,   1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], iv[i], lat);
      tests_run++;
      if (lat !== 8) begin
        tests_failed++;
        $display("FAIL extremes_latency[%0d] got %0d, expected 8", i, lat);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), lat);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_while_busy();
    int   d0;
    exp_t e;
    d0 = done_cnt;
    e  = model(8'd77, 8'd33, 1'b1);
    @(negedge clk);
    in_1 = 8'd77; in_2 = 8'd33; b_in = 1'b1; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; in_1 = 8'd1; in_2 = 8'd200; b_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    tests_run++;
    if (done_cnt - d0 !== 1) begin
      tests_failed++;
      $display("FAIL busy_start_pulses got %0d done pulses, expected 1", done_cnt - d0);
    end
    tests_run++;
    if (diff !== e.d || b_out !== e.bo || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_start_result diff=%0d b_out=%b busy=%b, expected %0d %b 0",
               diff, b_out, busy, e.d, e.bo);
    end
  endtask

  task automatic test_reset_mid_run();
    int d0, lat;
    @(negedge clk);
    in_1 = 8'd90; in_2 = 8'd17; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || b_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_run busy=%b done=%b diff=%0d b_out=%b, expected all 0", busy, done, diff, b_out);
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    d0 = done_cnt;
    repeat (12) @(posedge clk);
    #1;
    tests_run++;
    if (done_cnt !== d0) begin
      tests_failed++;
      $display("FAIL reset_no_done got %0d pulses after abort, expected 0", done_cnt - d0);
    end
    run_op(8'd100, 8'd1, 1'b0, lat);
    tests_run++;
    if (lat !== 8 || diff !== 8'd99 || b_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_recover lat=%0d diff=%0d b_out=%b, expected 8 99 0", lat, diff, b_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n0, t;
    n0 = done_cyc.size();
    @(negedge clk);
    in_1 = 8'd30; in_2 = 8'd20; b_in = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'd30, 8'd20, 1'b0));
    exp_q.push_back(model(8'd20, 8'd30, 1'b0));
    @(posedge clk); #1;
    in_1 = 8'd20; in_2 = 8'd30;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    in_1 = 8'd0; in_2 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1 || diff !== 8'd10 || b_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_hold busy=%b diff=%0d b_out=%b, expected 1 10 0", busy, diff, b_out);
    end
    t = 0;
    while (done_cyc.size() < n0 + 2 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (done_cyc.size() < n0 + 2) begin
      tests_failed++;
      $display("FAIL b2b_pulses got %0d done pulses, expected 2", done_cyc.size() - n0);
    end else if (done_cyc[n0+1] - done_cyc[n0] !== 10) begin
      tests_failed++;
      $display("FAIL b2b_spacing got %0d cycles, expected 10", done_cyc[n0+1] - done_cyc[n0]);
    end
    tests_run++;
    if (diff !== 8'd246 || b_out !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_final diff=%0d b_out=%b busy=%b, expected 246 1 0", diff, b_out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_extremes();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL missing_done %0d expected results never produced, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
